// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the binary-to-BCD sequencing stage and the digit-chain
// instantiation that sits downstream of it.
package bin2bcd_pkg;

  localparam int BIN_W_DEF  = 16;
  localparam int DIGITS_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_SHIFT   = 2'b01,
    ST_CAPTURE = 2'b10
  } state_e;

endpackage

// File: rtl/bin2bcd_shreg.sv
// Parallel-load, MSB-out left shifter feeding the serial input of the digit chain.
// Zeros fill from the LSB, so an exhausted register presents ser_out = 0.
module bin2bcd_shreg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] shreg_r;

  // Load has priority over shift; otherwise the register holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_r <= '0;
    end else if (load) begin
      shreg_r <= din;
    end else if (shift) begin
      shreg_r <= {shreg_r[W-2:0], 1'b0};
    end else begin
      shreg_r <= shreg_r;
    end
  end

  assign msb = shreg_r[W-1];

endmodule

// File: rtl/bin2bcd_ctrl.sv
// Sequencer for the BCD digit chain: sign/magnitude split, MSB-first streaming
// with done held low for BIN_W cycles, then capture of the chain result.
module bin2bcd_ctrl
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = BIN_W_DEF,
  parameter int DIGITS = DIGITS_DEF,
  parameter bit SIGNED = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  ser_out,
  output logic                  done,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  neg,
  output logic                  valid
);

  localparam int                CNT_W    = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BIN_W - 1);
  localparam logic [BIN_W-1:0]  MAG_ONE  = BIN_W'(1);

  state_e                state_r;
  state_e                next_state_s;
  logic [CNT_W-1:0]      cnt_r;
  logic                  neg_pending_r;
  logic [4*DIGITS-1:0]   bcd_out_r;
  logic                  neg_r;
  logic                  valid_r;
  logic                  done_r;
  logic                  busy_r;

  logic                  sign_s;
  logic [BIN_W-1:0]      mag_s;
  logic                  load_s;
  logic                  shift_s;
  logic                  capture_s;
  logic                  done_nxt_s;
  logic                  busy_nxt_s;

  // Two's-complement negate wraps 0x8000 onto itself, which read unsigned is 32768.
  assign sign_s = SIGNED && bin_in[BIN_W-1];
  assign mag_s  = sign_s ? (~bin_in + MAG_ONE) : bin_in;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          next_state_s = ST_SHIFT;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cnt_r == CNT_LAST) begin
          next_state_s = ST_CAPTURE;
        end else begin
          next_state_s = ST_SHIFT;
        end
      end
      ST_CAPTURE: next_state_s = ST_IDLE;
      default:    next_state_s = ST_IDLE;
    endcase
  end

  // Output/control decode; done and busy are registered from the next state.
  always_comb begin
    load_s     = 1'b0;
    shift_s    = 1'b0;
    capture_s  = 1'b0;
    done_nxt_s = (next_state_s != ST_SHIFT);
    busy_nxt_s = (next_state_s != ST_IDLE);
    case (state_r)
      ST_IDLE:    load_s    = start;
      ST_SHIFT:   shift_s   = 1'b1;
      ST_CAPTURE: capture_s = 1'b1;
      default: begin
        load_s    = 1'b0;
        shift_s   = 1'b0;
        capture_s = 1'b0;
      end
    endcase
  end

  // Bit counter and pending sign captured with the magnitude.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r         <= '0;
      neg_pending_r <= 1'b0;
    end else if (load_s) begin
      cnt_r         <= '0;
      neg_pending_r <= sign_s;
    end else if (shift_s) begin
      cnt_r         <= cnt_r + CNT_ONE;
      neg_pending_r <= neg_pending_r;
    end else begin
      cnt_r         <= cnt_r;
      neg_pending_r <= neg_pending_r;
    end
  end

  // Registered outputs: chain control, busy flag, result register and valid pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_r    <= 1'b1;
      busy_r    <= 1'b0;
      valid_r   <= 1'b0;
      bcd_out_r <= '0;
      neg_r     <= 1'b0;
    end else begin
      done_r  <= done_nxt_s;
      busy_r  <= busy_nxt_s;
      valid_r <= capture_s;
      if (capture_s) begin
        bcd_out_r <= bcd_in;
        neg_r     <= neg_pending_r;
      end else begin
        bcd_out_r <= bcd_out_r;
        neg_r     <= neg_r;
      end
    end
  end

  bin2bcd_shreg #(
    .W (BIN_W)
  ) u_shreg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load_s),
    .shift (shift_s),
    .din   (mag_s),
    .msb   (ser_out)
  );

  assign done    = done_r;
  assign busy    = busy_r;
  assign valid   = valid_r;
  assign bcd_out = bcd_out_r;
  assign neg     = neg_r;

endmodule

// File: tb/tb_bin2bcd_ctrl.sv
// Directed bench: a signed and an unsigned instance, each driving its own
// behavioural chain of add-3 BCD digit cells.
module tb_bin2bcd_ctrl;

  localparam int BIN_W  = 16;
  localparam int DIGITS = 5;

  logic clk;
  logic rst_n;
  logic start;
  logic [BIN_W-1:0] bin_in;

  logic sg_ser, sg_done, sg_busy, sg_neg, sg_valid;
  logic [4*DIGITS-1:0] sg_bcd_in, sg_bcd_out;
  logic us_ser, us_done, us_busy, us_neg, us_valid;
  logic [4*DIGITS-1:0] us_bcd_in, us_bcd_out;

  logic [3:0] sg_cell [DIGITS];
  logic [3:0] us_cell [DIGITS];
  logic [DIGITS:0] sg_chain;
  logic [DIGITS:0] us_chain;

  int checks;
  int failures;

  bin2bcd_ctrl #(.BIN_W(BIN_W), .DIGITS(DIGITS), .SIGNED(1'b1)) u_dut_sg (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
    .ser_out(sg_ser), .done(sg_done), .bcd_in(sg_bcd_in), .busy(sg_busy),
    .bcd_out(sg_bcd_out), .neg(sg_neg), .valid(sg_valid)
  );

  bin2bcd_ctrl #(.BIN_W(BIN_W), .DIGITS(DIGITS), .SIGNED(1'b0)) u_dut_us (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
    .ser_out(us_ser), .done(us_done), .bcd_in(us_bcd_in), .busy(us_busy),
    .bcd_out(us_bcd_out), .neg(us_neg), .valid(us_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One digit cell: add 3 when >= 5, then shift in the incoming bit.
  function automatic logic [3:0] cell_next(input logic [3:0] q, input logic d);
    logic [3:0] a;
    a = (q >= 4'd5) ? (q + 4'd3) : q;
    return {a[2:0], d};
  endfunction

  always_comb begin
    sg_chain[0] = sg_ser;
    us_chain[0] = us_ser;
    for (int k = 0; k < DIGITS; k++) begin
      sg_chain[k+1]      = (sg_cell[k] >= 4'd5);
      us_chain[k+1]      = (us_cell[k] >= 4'd5);
      sg_bcd_in[4*k +: 4] = sg_cell[k];
      us_bcd_in[4*k +: 4] = us_cell[k];
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < DIGITS; k++) begin
      sg_cell[k] <= sg_done ? 4'd0 : cell_next(sg_cell[k], sg_chain[k]);
      us_cell[k] <= us_done ? 4'd0 : cell_next(us_cell[k], us_chain[k]);
    end
  end

  // Pulse start for one cycle (optionally re-pulse at cycle inj_c) and record results.
  task automatic do_conv(input logic [15:0] val, input int inj_c, input logic [15:0] inj_val,
                         output int lat, output int dlow, output int nbusy, output int nvalid,
                         output logic [19:0] s_bcd, output logic s_neg,
                         output logic [19:0] u_bcd, output logic u_neg);
    lat = -1; dlow = 0; nbusy = 0; nvalid = 0;
    s_bcd = 20'hFFFFF; s_neg = 1'bx; u_bcd = 20'hFFFFF; u_neg = 1'bx;
    @(negedge clk);
    start = 1'b1;
    bin_in = val;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) begin
        start = 1'b0;
        bin_in = 16'hDEAD;
      end
      if (c == inj_c) begin
        start = 1'b1;
        bin_in = inj_val;
      end
      if (c == inj_c + 1) start = 1'b0;
      if (!sg_done) dlow++;
      if (sg_busy) nbusy++;
      if (sg_valid) begin
        nvalid++;
        if (lat < 0) lat = c;
        s_bcd = sg_bcd_out;
        s_neg = sg_neg;
      end
      if (us_valid) begin
        u_bcd = us_bcd_out;
        u_neg = us_neg;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; start = 1'b0; bin_in = 16'h0000;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 7;
    if (sg_done !== 1'b1) begin failures++; $display("FAIL rst_done got=%b exp=1", sg_done); end
    if (sg_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", sg_busy); end
    if (sg_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", sg_valid); end
    if (sg_neg !== 1'b0) begin failures++; $display("FAIL rst_neg got=%b exp=0", sg_neg); end
    if (sg_bcd_out !== 20'h00000) begin failures++; $display("FAIL rst_bcd got=%h exp=00000", sg_bcd_out); end
    if (sg_ser !== 1'b0) begin failures++; $display("FAIL rst_ser got=%b exp=0", sg_ser); end
    if (us_done !== 1'b1) begin failures++; $display("FAIL rst_us_done got=%b exp=1", us_done); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, dlow, nbusy, nvalid; logic [19:0] sb, ub; logic sn, un;
    do_conv(16'd1234, -1, 16'h0000, lat, dlow, nbusy, nvalid, sb, sn, ub, un);
    checks += 7;
    if (lat !== 17) begin failures++; $display("FAIL basic_latency got=%0d exp=17", lat); end
    if (dlow !== 16) begin failures++; $display("FAIL basic_done_low got=%0d exp=16", dlow); end
    if (nbusy !== 17) begin failures++; $display("FAIL basic_busy got=%0d exp=17", nbusy); end
    if (nvalid !== 1) begin failures++; $display("FAIL basic_valid_cnt got=%0d exp=1", nvalid); end
    if (sb !== 20'h01234) begin failures++; $display("FAIL basic_bcd got=%h exp=01234", sb); end
    if (sn !== 1'b0) begin failures++; $display("FAIL basic_neg got=%b exp=0", sn); end
    if (ub !== 20'h01234) begin failures++; $display("FAIL basic_us_bcd got=%h exp=01234", ub); end
  endtask

  task automatic test_sign();
    int lat, dlow, nbusy, nvalid; logic [19:0] sb, ub; logic sn, un;
    do_conv(16'hFFFF, -1, 16'h0000, lat, dlow, nbusy, nvalid, sb, sn, ub, un);
    checks += 4;
    if (sb !== 20'h00001) begin failures++; $display("FAIL neg1_bcd got=%h exp=00001", sb); end
    if (sn !== 1'b1) begin failures++; $display("FAIL neg1_neg got=%b exp=1", sn); end
    if (ub !== 20'h65535) begin failures++; $display("FAIL u65535_bcd got=%h exp=65535", ub); end
    if (un !== 1'b0) begin failures++; $display("FAIL u65535_neg got=%b exp=0", un); end
    do_conv(16'h8000, -1, 16'h0000, lat, dlow, nbusy, nvalid, sb, sn, ub, un);
    checks += 4;
    if (sb !== 20'h32768) begin failures++; $display("FAIL min_bcd got=%h exp=32768", sb); end
    if (sn !== 1'b1) begin failures++; $display("FAIL min_neg got=%b exp=1", sn); end
    if (ub !== 20'h32768) begin failures++; $display("FAIL u32768_bcd got=%h exp=32768", ub); end
    if (un !== 1'b0) begin failures++; $display("FAIL u32768_neg got=%b exp=0", un); end
  endtask

  task automatic test_zero();
    int lat, dlow, nbusy, nvalid; logic [19:0] sb, ub; logic sn, un;
    do_conv(16'h0000, -1, 16'h0000, lat, dlow, nbusy, nvalid, sb, sn, ub, un);
    checks += 4;
    if (nvalid !== 1) begin failures++; $display("FAIL zero_valid_cnt got=%0d exp=1", nvalid); end
    if (sb !== 20'h00000) begin failures++; $display("FAIL zero_bcd got=%h exp=00000", sb); end
    if (sn !== 1'b0) begin failures++; $display("FAIL zero_neg got=%b exp=0", sn); end
    if (ub !== 20'h00000) begin failures++; $display("FAIL zero_us_bcd got=%h exp=00000", ub); end
  endtask

  task automatic test_ignored_start();
    int lat, dlow, nbusy, nvalid; logic [19:0] sb, ub; logic sn, un;
    do_conv(16'd512, 5, 16'd9999, lat, dlow, nbusy, nvalid, sb, sn, ub, un);
    checks += 3;
    if (nvalid !== 1) begin failures++; $display("FAIL ign_valid_cnt got=%0d exp=1", nvalid); end
    if (lat !== 17) begin failures++; $display("FAIL ign_latency got=%0d exp=17", lat); end
    if (sb !== 20'h00512) begin failures++; $display("FAIL ign_bcd got=%h exp=00512", sb); end
  endtask

  task automatic test_reset_mid_shift();
    int lat, dlow, nbusy, nvalid, nv; logic [19:0] sb, ub; logic sn, un;
    @(negedge clk);
    start = 1'b1;
    bin_in = 16'd777;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (sg_done !== 1'b1) begin failures++; $display("FAIL mid_rst_done got=%b exp=1", sg_done); end
    if (sg_busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%b exp=0", sg_busy); end
    if (sg_bcd_out !== 20'h00000) begin failures++; $display("FAIL mid_rst_bcd got=%h exp=00000", sg_bcd_out); end
    if (sg_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b exp=0", sg_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    nv = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (sg_valid) nv++;
    end
    checks += 1;
    if (nv !== 0) begin failures++; $display("FAIL mid_rst_no_valid got=%0d exp=0", nv); end
    do_conv(16'd42, -1, 16'h0000, lat, dlow, nbusy, nvalid, sb, sn, ub, un);
    checks += 2;
    if (sb !== 20'h00042) begin failures++; $display("FAIL after_rst_bcd got=%h exp=00042", sb); end
    if (lat !== 17) begin failures++; $display("FAIL after_rst_latency got=%0d exp=17", lat); end
  endtask

  // Start held high: the second accept lands on the edge that closes the valid cycle.
  task automatic test_back_to_back();
    int t1, t2, nv; logic [19:0] v1, v2;
    t1 = -1; t2 = -1; nv = 0; v1 = 20'hFFFFF; v2 = 20'hFFFFF;
    @(negedge clk);
    start = 1'b1;
    bin_in = 16'd7;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (c == 0) bin_in = 16'd300;
      if (c == 18) start = 1'b0;
      if (sg_valid) begin
        nv++;
        if (t1 < 0) begin t1 = c; v1 = sg_bcd_out; end
        else begin t2 = c; v2 = sg_bcd_out; end
      end
    end
    checks += 5;
    if (nv !== 2) begin failures++; $display("FAIL b2b_valid_cnt got=%0d exp=2", nv); end
    if (t1 !== 17) begin failures++; $display("FAIL b2b_first_time got=%0d exp=17", t1); end
    if (t2 !== 35) begin failures++; $display("FAIL b2b_second_time got=%0d exp=35", t2); end
    if (v1 !== 20'h00007) begin failures++; $display("FAIL b2b_first_bcd got=%h exp=00007", v1); end
    if (v2 !== 20'h00300) begin failures++; $display("FAIL b2b_second_bcd got=%h exp=00300", v2); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_sign();
    test_zero();
    test_ignored_start();
    test_reset_mid_shift();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
